cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Conditional-execution stage, directly downstream of the instruction decoder in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register and evaluates the instruction's condition field (Instr[31:28]) against the current flags.
- Gates the decoder's PCS/RegW/MemW/NoWrite into the final PCSrc/RegWrite/MemWrite strobes, and updates flags from ALUFlags under FlagW.
- Keeps saturating executed/squashed instruction counters for debug.

Parameters:
CNT_W, 32, width of ExecCount and SquashCount

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET  input  1  synchronous, active-low reset
Cond  input  4  condition field Instr[31:28]
ALUFlags  input  4  {N,Z,C,V} from ALU for the current instruction
FlagW  input  2  from decoder; [1] enables N,Z update, [0] enables C,V update
PCS  input  1  from decoder; instruction writes PC
RegW  input  1  from decoder; instruction writes register file
MemW  input  1  from decoder; instruction writes data memory
NoWrite  input  1  from decoder; CMP/CMN, suppresses register write
Stall  input  1  hold: current instruction does not retire this cycle
ClrCnt  input  1  synchronous clear of both counters
PCSrc  output  1  PC source select, gated
RegWrite  output  1  register-file write enable, gated
MemWrite  output  1  data-memory write enable, gated
CondEx  output  1  condition passed, combinational
Flags  output  4  registered {N,Z,C,V}
ExecCount  output  CNT_W  retired instructions with CondEx=1
SquashCount  output  CNT_W  retired instructions with CondEx=0

Behaviour:
- Reset (RESET=0 at a rising edge):
  - Flags <= 4'b0000; ExecCount <= 0; SquashCount <= 0.
  - While RESET=0: PCSrc, RegWrite and MemWrite are forced to 0 combinationally.
- CondEx is combinational from Cond and the registered Flags (pre-update values), using N,Z,C,V = Flags[3:0]:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (treated as never; instruction squashed)
- Gating, with G = CondEx & !Stall & RESET:
  - PCSrc = PCS & G
  - RegWrite = RegW & !NoWrite & G
  - MemWrite = MemW & G
- Zero-latency outputs: the decoder-to-strobe path is purely combinational.
- Flag update on a rising edge when RESET=1, !Stall and CondEx:
  - If FlagW[1]: Flags[3:2] <= ALUFlags[3:2].
  - If FlagW[0]: Flags[1:0] <= ALUFlags[1:0].
  - Otherwise the flags hold.
- Flags change is visible from the next cycle. An instruction never sees its own flag result. A conditional flag-setting instruction is tested against the old flags.
- Squashed instruction (CondEx=0): no flag update, all strobes 0.
- Counters, on a rising edge when RESET=1:
  - ClrCnt=1: both counters <= 0. Clear wins over a simultaneous increment.
  - Else if !Stall: CondEx ? ExecCount++ : SquashCount++.
  - Each counter saturates at all-ones and never wraps.
  - Stall=1: counters hold.
- Stall=1: flags and counters frozen; strobes 0; CondEx still reflects the evaluation.
- Reset mid-stall or mid-sequence: reset has priority over Stall, ClrCnt and flag writes.
- FlagW=2'b00 with CondEx=1: flags unchanged, ExecCount increments.
- X-free: every output is defined for all 16 Cond values.

Test Plan:
- Reset then SUBS-like cycle (Cond=1110, FlagW=11, ALUFlags=0100, RegW=1) -> RegWrite=1 that cycle, Flags=0100 next cycle, ExecCount=1.
- Flags=0100, Cond=0000 (EQ) with MemW=1 -> MemWrite=1. Then Cond=0001 (NE) with PCS=1 -> PCSrc=0 and SquashCount=1.
- CMP (RegW=1, NoWrite=1, FlagW=11, ALUFlags=1000, Cond=1110) -> RegWrite=0, Flags=1000 next cycle. Then Cond=1011 (LT) -> CondEx=1; Cond=1010 (GE) -> CondEx=0.
- FlagW=10 with ALUFlags=1111 from Flags=0000 -> Flags=1100 (C,V unchanged). Then FlagW=01 with ALUFlags=0000 -> Flags=1100.
- Stall=1 with Cond=1110, RegW=1, FlagW=11, ALUFlags=0110 -> RegWrite=0, Flags and counters unchanged. Drop Stall -> RegWrite=1, update applied.
- CNT_W=4 build: 20 AL cycles -> ExecCount saturates at 4'hF. ClrCnt together with an AL instruction -> ExecCount=0. RESET=0 mid-run -> Flags=0000 and counters 0 on the next edge.

Source files
------------

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// Module      : cond_logic
// Description : ARM conditional-execution stage. Holds NZCV flags, evaluates
//               the condition field, gates decoder strobes, and keeps
//               saturating executed/squashed instruction counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_logic #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             Stall,
    input  logic             ClrCnt,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] squash_q, squash_d;
    logic             w_n, w_z, w_c, w_v;
    logic             w_cond_ex;
    logic             w_gate;

    assign {w_n, w_z, w_c, w_v} = flags_q;

    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Strobes are forced low during reset, stall, or a failed condition.
    assign w_gate   = w_cond_ex & ~Stall & RESET;
    assign PCSrc    = PCS & w_gate;
    assign RegWrite = RegW & ~NoWrite & w_gate;
    assign MemWrite = MemW & w_gate;
    assign CondEx   = w_cond_ex;

    always_comb begin
        flags_d  = flags_q;
        exec_d   = exec_q;
        squash_d = squash_q;
        if (!Stall && w_cond_ex) begin
            if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
        end
        if (ClrCnt) begin
            exec_d   = '0;
            squash_d = '0;
        end else if (!Stall) begin
            if (w_cond_ex) begin
                if (exec_q != C_CNT_MAX) exec_d = exec_q + CNT_W'(1);
            end else begin
                if (squash_q != C_CNT_MAX) squash_d = squash_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            flags_q  <= 4'b0000;
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            flags_q  <= flags_d;
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end

    assign Flags       = flags_q;
    assign ExecCount   = exec_q;
    assign SquashCount = squash_q;

endmodule
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_logic
// Description : Self-checking bench for cond_logic (32-bit and 4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_logic;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  Cond, ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS, RegW, MemW, NoWrite, Stall, ClrCnt;

    logic        PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]  Flags;
    logic [31:0] ExecCount, SquashCount;
    logic        PCSrc4, RegWrite4, MemWrite4, CondEx4;
    logic [3:0]  Flags4;
    logic [3:0]  ExecCount4, SquashCount4;

    always #5 CLK = ~CLK;

    cond_logic #(.CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Stall(Stall),
        .ClrCnt(ClrCnt), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx), .Flags(Flags), .ExecCount(ExecCount), .SquashCount(SquashCount)
    );

    cond_logic #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Stall(Stall),
        .ClrCnt(ClrCnt), .PCSrc(PCSrc4), .RegWrite(RegWrite4), .MemWrite(MemWrite4),
        .CondEx(CondEx4), .Flags(Flags4), .ExecCount(ExecCount4), .SquashCount(SquashCount4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [3:0] m_flags;
    longint     m_exec, m_squash, m_exec4, m_squash4;
    localparam longint MAX32 = 64'hFFFF_FFFF;
    localparam longint MAX4  = 15;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ARM rule: Cond[3:1] picks a base test, Cond[0] inverts it; 1111 never.
    function automatic logic mcond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic longint sat_inc(input longint x, input longint mx);
        return (x >= mx) ? mx : x + 1;
    endfunction

    // Called #1 after the negedge drive; checks combinational outputs,
    // advances the model across the next posedge and checks state.
    task automatic run_cycle();
        logic ce, g;
        logic [3:0] nf;
        longint ne, ns, ne4, ns4;
        ce = mcond(Cond, m_flags);
        g  = ce && !Stall && RESET;
        chk("CondEx",   64'(CondEx),   64'(ce));
        chk("PCSrc",    64'(PCSrc),    64'(PCS && g));
        chk("RegWrite", 64'(RegWrite), 64'(RegW && !NoWrite && g));
        chk("MemWrite", 64'(MemWrite), 64'(MemW && g));
        chk("RegWrite4", 64'(RegWrite4), 64'(RegW && !NoWrite && g));
        nf = m_flags; ne = m_exec; ns = m_squash; ne4 = m_exec4; ns4 = m_squash4;
        if (!RESET) begin
            nf = 4'h0; ne = 0; ns = 0; ne4 = 0; ns4 = 0;
        end else begin
            if (!Stall && ce) begin
                if (FlagW[1]) nf[3:2] = ALUFlags[3:2];
                if (FlagW[0]) nf[1:0] = ALUFlags[1:0];
            end
            if (ClrCnt) begin
                ne = 0; ns = 0; ne4 = 0; ns4 = 0;
            end else if (!Stall) begin
                if (ce) begin ne = sat_inc(ne, MAX32); ne4 = sat_inc(ne4, MAX4); end
                else    begin ns = sat_inc(ns, MAX32); ns4 = sat_inc(ns4, MAX4); end
            end
        end
        @(posedge CLK);
        #1;
        m_flags = nf; m_exec = ne; m_squash = ns; m_exec4 = ne4; m_squash4 = ns4;
        chk("Flags",        64'(Flags),        64'(m_flags));
        chk("ExecCount",    64'(ExecCount),    64'(m_exec));
        chk("SquashCount",  64'(SquashCount),  64'(m_squash));
        chk("Flags4",       64'(Flags4),       64'(m_flags));
        chk("ExecCount4",   64'(ExecCount4),   64'(m_exec4));
        chk("SquashCount4", 64'(SquashCount4), 64'(m_squash4));
    endtask

    task automatic set_in(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                          input logic pcs, input logic rw, input logic mw, input logic nw,
                          input logic st, input logic clr, input logic rst);
        Cond = c; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = rw; MemW = mw;
        NoWrite = nw; Stall = st; ClrCnt = clr; RESET = rst;
    endtask

    task automatic apply(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic rw, input logic mw, input logic nw,
                         input logic st, input logic clr, input logic rst);
        @(negedge CLK);
        set_in(c, alu, fw, pcs, rw, mw, nw, st, clr, rst);
        #1;
        run_cycle();
    endtask

    typedef struct {
        logic [3:0] cond; logic [3:0] alu; logic [1:0] fw;
        logic pcs, rw, mw, nw, st, clr;
        logic e_condex, e_pcsrc, e_regwrite, e_memwrite;
        logic [3:0] e_flags; int e_exec; int e_squash;
    } vec_t;

    vec_t vt[15];

    initial begin
        //          cond   alu    fw   pcs rw mw nw st clr | ce pc rw mw flags  ex sq
        vt[0]  = '{4'hE, 4'h4, 2'b11, 0,1,0,0,0,0,  1,0,1,0, 4'h4, 1, 0};
        vt[1]  = '{4'h0, 4'h0, 2'b00, 0,0,1,0,0,0,  1,0,0,1, 4'h4, 2, 0};
        vt[2]  = '{4'h1, 4'h0, 2'b00, 1,0,0,0,0,0,  0,0,0,0, 4'h4, 2, 1};
        vt[3]  = '{4'hE, 4'h8, 2'b11, 0,1,0,1,0,0,  1,0,0,0, 4'h8, 3, 1};
        vt[4]  = '{4'hB, 4'h0, 2'b00, 0,0,0,0,0,0,  1,0,0,0, 4'h8, 4, 1};
        vt[5]  = '{4'hA, 4'h0, 2'b00, 0,0,0,0,0,0,  0,0,0,0, 4'h8, 4, 2};
        vt[6]  = '{4'hE, 4'h0, 2'b11, 0,0,0,0,0,0,  1,0,0,0, 4'h0, 5, 2};
        vt[7]  = '{4'hE, 4'hF, 2'b10, 0,0,0,0,0,0,  1,0,0,0, 4'hC, 6, 2};
        vt[8]  = '{4'hE, 4'h0, 2'b01, 0,0,0,0,0,0,  1,0,0,0, 4'hC, 7, 2};
        vt[9]  = '{4'hE, 4'h6, 2'b11, 0,1,0,0,1,0,  1,0,0,0, 4'hC, 7, 2};
        vt[10] = '{4'hE, 4'h6, 2'b11, 0,1,0,0,0,0,  1,0,1,0, 4'h6, 8, 2};
        vt[11] = '{4'h0, 4'h0, 2'b11, 0,0,0,0,0,0,  1,0,0,0, 4'h0, 9, 2};
        vt[12] = '{4'h0, 4'h4, 2'b11, 1,1,1,0,0,0,  0,0,0,0, 4'h0, 9, 3};
        vt[13] = '{4'hF, 4'hF, 2'b11, 1,1,1,0,0,0,  0,0,0,0, 4'h0, 9, 4};
        vt[14] = '{4'hE, 4'h0, 2'b00, 0,0,0,0,0,1,  1,0,0,0, 4'h0, 0, 0};

        set_in(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
        @(posedge CLK); @(posedge CLK); #1;
        chk("rst_Flags",  64'(Flags),       64'h0);
        chk("rst_Exec",   64'(ExecCount),   64'h0);
        chk("rst_Squash", 64'(SquashCount), 64'h0);
        chk("rst_RegWrite_low", 64'(RegWrite), 64'h0);
        m_flags = 4'h0; m_exec = 0; m_squash = 0; m_exec4 = 0; m_squash4 = 0;

        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            set_in(vt[i].cond, vt[i].alu, vt[i].fw, vt[i].pcs, vt[i].rw, vt[i].mw,
                   vt[i].nw, vt[i].st, vt[i].clr, 1'b1);
            #1;
            chk($sformatf("vec%0d_CondEx", i),   64'(CondEx),   64'(vt[i].e_condex));
            chk($sformatf("vec%0d_PCSrc", i),    64'(PCSrc),    64'(vt[i].e_pcsrc));
            chk($sformatf("vec%0d_RegWrite", i), 64'(RegWrite), 64'(vt[i].e_regwrite));
            chk($sformatf("vec%0d_MemWrite", i), 64'(MemWrite), 64'(vt[i].e_memwrite));
            run_cycle();
            chk($sformatf("vec%0d_Flags", i),  64'(Flags),       64'(vt[i].e_flags));
            chk($sformatf("vec%0d_Exec", i),   64'(ExecCount),   64'(vt[i].e_exec));
            chk($sformatf("vec%0d_Squash", i), 64'(SquashCount), 64'(vt[i].e_squash));
        end

        for (int i = 0; i < 400; i++) begin
            apply(4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 39) != 0));
        end

        // Saturation of the 4-bit counter
        apply(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++) apply(4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 1);
        chk("sat_Exec4",  64'(ExecCount4), 64'hF);
        chk("sat_Exec32", 64'(ExecCount),  64'd20);
        apply(4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 1, 1);
        chk("clr_wins_Exec4", 64'(ExecCount4), 64'h0);
        chk("clr_wins_Exec",  64'(ExecCount),  64'h0);

        // Reset mid-run has priority over Stall and flag writes
        apply(4'hE, 4'hF, 2'b11, 0, 1, 0, 0, 0, 0, 1);
        apply(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("pre_rst_Flags", 64'(Flags), 64'hF);
        @(negedge CLK);
        set_in(4'hE, 4'h5, 2'b11, 1, 1, 1, 0, 1, 1, 1'b0);
        #1;
        chk("rst_forces_PCSrc",    64'(PCSrc),    64'h0);
        chk("rst_forces_MemWrite", 64'(MemWrite), 64'h0);
        run_cycle();
        chk("midrst_Flags",  64'(Flags),      64'h0);
        chk("midrst_Exec",   64'(ExecCount),  64'h0);
        chk("midrst_Squash", 64'(SquashCount), 64'h0);
        apply(4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
